operand_fetch: RTL and testbench

Register-read stage between instruction decode and execute. Drives read addresses to the register file, merges the returned operands with bypass data from EX, MEM and WB, and detects load-use hazards. Captures the result into a single-entry ID/EX pipeline register with a valid/ready handshake on both sides.

---
 rtl/opfetch_pkg.sv | 7 +
 rtl/operand_fetch_if.sv | 23 ++
 rtl/operand_bypass_mux.sv | 45 ++++
 rtl/operand_fetch.sv | 75 +++++++
 tb/tb_operand_fetch.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/opfetch_pkg.sv
// opfetch_pkg: shared widths and operand-source encoding for the operand fetch stage.
package opfetch_pkg;
   localparam int XLEN   = 32;
   localparam int CW     = 8;
   localparam int REG_AW = 5;
   typedef enum logic [2:0] {SRC_ZERO, SRC_EX, SRC_MEM, SRC_WB, SRC_RF} src_t;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side and execute-side valid/ready handshakes of the operand fetch stage.
interface operand_fetch_if;
   import opfetch_pkg::*;
   logic              in_valid, in_ready;
   logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
   logic              in_use_rs1, in_use_rs2, in_we, in_is_load;
   logic [XLEN-1:0]   in_imm, in_pc;
   logic [CW-1:0]     in_ctrl;
   logic              out_valid, out_ready;
   logic [XLEN-1:0]   out_rs1_val, out_rs2_val;
   logic [REG_AW-1:0] out_rd;
   logic              out_we, out_is_load;
   logic [XLEN-1:0]   out_imm, out_pc;
   logic [CW-1:0]     out_ctrl;
   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_we, in_is_load, in_imm, in_pc, in_ctrl, out_ready,
      output in_ready, out_valid, out_rs1_val, out_rs2_val, out_rd, out_we, out_is_load, out_imm, out_pc, out_ctrl
   );
   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_we, in_is_load, in_imm, in_pc, in_ctrl, out_ready,
      input  in_ready, out_valid, out_rs1_val, out_rs2_val, out_rd, out_we, out_is_load, out_imm, out_pc, out_ctrl
   );
endinterface

// File: rtl/operand_bypass_mux.sv
// operand_bypass_mux: priority source select and load-use hazard for one source register.
// OPFETCH_FORWARD_EN enables the EX/MEM/WB bypass; otherwise any EX/MEM writer of rs stalls.
module operand_bypass_mux
   import opfetch_pkg::*;
(
   input  logic [REG_AW-1:0] rs,
   input  logic              use_rs,
   input  logic              ex_valid,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [XLEN-1:0]   ex_data,
   input  logic              mem_valid,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic [XLEN-1:0]   rf_data,
   output logic [XLEN-1:0]   val,
   output logic              hazard
);
   src_t src;
   logic nz;
   assign nz = rs != '0;
`ifndef OPFETCH_FORWARD_EN
   logic unused;
   assign unused = ex_is_load ^ wb_we ^ (^wb_rd);
`endif
   always_comb begin
`ifdef OPFETCH_FORWARD_EN
      src = !nz ? SRC_ZERO :
            (ex_valid && ex_rd == rs && !ex_is_load) ? SRC_EX :
            (mem_valid && mem_rd == rs) ? SRC_MEM :
            (wb_we && wb_rd == rs) ? SRC_WB : SRC_RF;
      hazard = use_rs && nz && ex_valid && ex_is_load && ex_rd == rs;
`else
      src = nz ? SRC_RF : SRC_ZERO;
      hazard = use_rs && nz && ((ex_valid && ex_rd == rs) || (mem_valid && mem_rd == rs));
`endif
      val = src == SRC_EX  ? ex_data  :
            src == SRC_MEM ? mem_data :
            src == SRC_WB  ? wb_data  :
            src == SRC_RF  ? rf_data  : '0;
   end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with bypass, load-use stall and a single-entry ID/EX register.
// Build with OPFETCH_FORWARD_EN for the full bypass network; default stalls on any EX/MEM producer.
module operand_fetch
   import opfetch_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   operand_fetch_if.slave    bus,
   output logic [REG_AW-1:0] rf_rs1,
   output logic [REG_AW-1:0] rf_rs2,
   input  logic [XLEN-1:0]   rf_rrs1,
   input  logic [XLEN-1:0]   rf_rrs2,
   input  logic              ex_valid,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [XLEN-1:0]   ex_data,
   input  logic              mem_valid,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic [31:0]       hazard_cnt
);
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            hz1, hz2, hazard, accept;
   assign rf_rs1 = bus.in_rs1;
   assign rf_rs2 = bus.in_rs2;
   operand_bypass_mux u_rs1 (
      .rs(bus.in_rs1), .use_rs(bus.in_use_rs1),
      .ex_valid, .ex_is_load, .ex_rd, .ex_data, .mem_valid, .mem_rd, .mem_data, .wb_we, .wb_rd, .wb_data,
      .rf_data(rf_rrs1), .val(rs1_val), .hazard(hz1)
   );
   operand_bypass_mux u_rs2 (
      .rs(bus.in_rs2), .use_rs(bus.in_use_rs2),
      .ex_valid, .ex_is_load, .ex_rd, .ex_data, .mem_valid, .mem_rd, .mem_data, .wb_we, .wb_rd, .wb_data,
      .rf_data(rf_rrs2), .val(rs2_val), .hazard(hz2)
   );
   assign hazard       = hz1 || hz2;
   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !flush;
   assign accept       = bus.in_valid && bus.in_ready;
   // Fields are written only on accept, so a stalled output stays bit-stable.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bus.out_valid   <= 1'b0;
         bus.out_rs1_val <= '0;
         bus.out_rs2_val <= '0;
         bus.out_rd      <= '0;
         bus.out_we      <= 1'b0;
         bus.out_is_load <= 1'b0;
         bus.out_imm     <= '0;
         bus.out_pc      <= '0;
         bus.out_ctrl    <= '0;
      end else if (flush) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid   <= 1'b1;
         bus.out_rs1_val <= rs1_val;
         bus.out_rs2_val <= rs2_val;
         bus.out_rd      <= bus.in_rd;
         bus.out_we      <= bus.in_we;
         bus.out_is_load <= bus.in_is_load;
         bus.out_imm     <= bus.in_imm;
         bus.out_pc      <= bus.in_pc;
         bus.out_ctrl    <= bus.in_ctrl;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) hazard_cnt <= '0;
      else if (bus.in_valid && hazard && !flush) hazard_cnt <= hazard_cnt + 32'd1;
   end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus randomized traffic against a behavioural model.
// Expectations follow OPFETCH_FORWARD_EN the same way the design does.
module tb_operand_fetch;
   logic        CLK = 1'b0;
   logic        RST;
   logic [4:0]  rf_rs1, rf_rs2, ex_rd, mem_rd, wb_rd;
   logic [31:0] rf_rrs1, rf_rrs2, ex_data, mem_data, wb_data, hazard_cnt;
   logic        ex_valid, ex_is_load, mem_valid, wb_we, flush;
   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;

   operand_fetch_if bus ();

   operand_fetch dut (
      .CLK(CLK), .RST(RST), .bus(bus),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rrs1(rf_rrs1), .rf_rrs2(rf_rrs2),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .hazard_cnt(hazard_cnt)
   );

   function automatic logic [143:0] obs();
      return {bus.out_valid, bus.out_rs1_val, bus.out_rs2_val, bus.out_rd, bus.out_we,
              bus.out_is_load, bus.out_imm, bus.out_pc, bus.out_ctrl};
   endfunction

   // Reference operand: what the architectural value of rs is this cycle.
   function automatic logic [31:0] m_opnd(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 5'd0) return 32'd0;
`ifdef OPFETCH_FORWARD_EN
      if (ex_valid && !ex_is_load && ex_rd == rs) return ex_data;
      if (mem_valid && mem_rd == rs) return mem_data;
      if (wb_we && wb_rd == rs) return wb_data;
`endif
      return rf;
   endfunction

   function automatic logic m_stall(input logic [4:0] rs, input logic use_rs);
      if (!use_rs || rs == 5'd0) return 1'b0;
`ifdef OPFETCH_FORWARD_EN
      return ex_valid && ex_is_load && ex_rd == rs;
`else
      return (ex_valid && ex_rd == rs) || (mem_valid && mem_rd == rs);
`endif
   endfunction

   task automatic idle();
      bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
      bus.in_use_rs1 = 1; bus.in_use_rs2 = 1; bus.in_we = 0; bus.in_is_load = 0;
      bus.in_imm = 0; bus.in_pc = 0; bus.in_ctrl = 0; bus.out_ready = 1;
      rf_rrs1 = 0; rf_rrs2 = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0;
   endtask

   task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] pc);
      bus.in_valid = 1; bus.in_rs1 = r1; bus.in_rs2 = r2; bus.in_rd = rd;
      bus.in_use_rs1 = 1; bus.in_use_rs2 = 1; bus.in_we = 1; bus.in_is_load = 0;
      bus.in_imm = pc ^ 32'h5a5a; bus.in_pc = pc; bus.in_ctrl = pc[7:0];
   endtask

   task automatic test_reset();
      idle();
      RST = 1; issue(5'd1, 5'd2, 5'd3, 32'hdead); rf_rrs1 = 32'h1234; ex_valid = 1; ex_is_load = 1; ex_rd = 5'd1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++; if (obs() !== 144'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs()); end
      checks++; if (hazard_cnt !== 32'd0) begin errors++; $display("FAIL reset_hazard_cnt got %h want 0", hazard_cnt); end
      RST = 0; idle();
   endtask

   task automatic test_basic();
      @(negedge CLK);
      idle(); issue(5'd3, 5'd4, 5'd8, 32'h100); rf_rrs1 = 32'h11; rf_rrs2 = 32'h22;
      #1;
      checks++; if ({rf_rs1, rf_rs2} !== {5'd3, 5'd4}) begin errors++; $display("FAIL rf_addr got %h want %h", {rf_rs1, rf_rs2}, {5'd3, 5'd4}); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b want 1", bus.in_ready); end
      @(negedge CLK);
      checks++;
      if (obs() !== {1'b1, 32'h11, 32'h22, 5'd8, 1'b1, 1'b0, 32'h100 ^ 32'h5a5a, 32'h100, 8'h00}) begin
         errors++; $display("FAIL basic_capture got %h", obs());
      end
   endtask

   task automatic test_ex_priority();
      @(negedge CLK);
      idle(); issue(5'd5, 5'd6, 5'd9, 32'h200); rf_rrs1 = 32'hDDDD; rf_rrs2 = 32'h66;
      ex_valid = 1; ex_rd = 5'd5; ex_data = 32'hAAAA; mem_valid = 1; mem_rd = 5'd5; mem_data = 32'hBBBB;
      wb_we = 1; wb_rd = 5'd5; wb_data = 32'hCCCC;
      #1;
`ifdef OPFETCH_FORWARD_EN
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL exprio_in_ready got %b want 1", bus.in_ready); end
      @(negedge CLK);
      checks++; if ({bus.out_rs1_val, bus.out_rs2_val} !== {32'hAAAA, 32'h66}) begin errors++; $display("FAIL exprio_ex got %h want %h", {bus.out_rs1_val, bus.out_rs2_val}, {32'hAAAA, 32'h66}); end
      ex_valid = 0;
      @(negedge CLK);
      checks++; if (bus.out_rs1_val !== 32'hBBBB) begin errors++; $display("FAIL exprio_mem got %h want BBBB", bus.out_rs1_val); end
      mem_valid = 0;
      @(negedge CLK);
      checks++; if (bus.out_rs1_val !== 32'hCCCC) begin errors++; $display("FAIL exprio_wb got %h want CCCC", bus.out_rs1_val); end
`else
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL exprio_in_ready got %b want 0", bus.in_ready); end
      @(negedge CLK);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL exprio_stall_valid got %b want 0", bus.out_valid); end
      ex_valid = 0; mem_valid = 0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL exprio_wb_no_stall got %b want 1", bus.in_ready); end
      @(negedge CLK);
      checks++; if (bus.out_rs1_val !== 32'hDDDD) begin errors++; $display("FAIL exprio_rf got %h want DDDD", bus.out_rs1_val); end
`endif
   endtask

   task automatic test_load_use();
      logic [31:0] c0;
      @(negedge CLK);
      idle(); issue(5'd1, 5'd7, 5'd2, 32'h300); rf_rrs1 = 32'h1; rf_rrs2 = 32'h9999;
      ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7; c0 = hazard_cnt;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL loaduse_stall got %b want 0", bus.in_ready); end
      @(negedge CLK);
      checks++; if (hazard_cnt !== c0 + 32'd1) begin errors++; $display("FAIL loaduse_cnt got %h want %h", hazard_cnt, c0 + 32'd1); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL loaduse_no_capture got %b want 0", bus.out_valid); end
      ex_valid = 0; ex_is_load = 0; mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h1234;
`ifndef OPFETCH_FORWARD_EN
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL loaduse_mem_stall got %b want 0", bus.in_ready); end
      @(negedge CLK);
      mem_valid = 0; rf_rrs2 = 32'h1234;
`endif
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL loaduse_release got %b want 1", bus.in_ready); end
      @(negedge CLK);
      checks++; if ({bus.out_valid, bus.out_rs2_val} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL loaduse_value got %h want %h", {bus.out_valid, bus.out_rs2_val}, {1'b1, 32'h1234}); end
      mem_valid = 0; ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7; bus.in_use_rs2 = 0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL loaduse_unused_rs got %b want 1", bus.in_ready); end
   endtask

   task automatic test_x0();
      @(negedge CLK);
      idle(); issue(5'd0, 5'd0, 5'd1, 32'h400); rf_rrs1 = 32'h5555; rf_rrs2 = 32'h6666;
      ex_valid = 1; ex_rd = 5'd0; ex_data = 32'hFFFF; mem_valid = 1; mem_rd = 5'd0; mem_data = 32'hEEEE;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL x0_in_ready got %b want 1", bus.in_ready); end
      @(negedge CLK);
      checks++; if ({bus.out_rs1_val, bus.out_rs2_val} !== 64'd0) begin errors++; $display("FAIL x0_value got %h want 0", {bus.out_rs1_val, bus.out_rs2_val}); end
   endtask

   task automatic test_stall();
      logic [143:0] held;
      @(negedge CLK);
      idle(); issue(5'd2, 5'd3, 5'd4, 32'h40); rf_rrs1 = 32'h100; rf_rrs2 = 32'h200;
      held = {1'b1, 32'h100, 32'h200, 5'd4, 1'b1, 1'b0, 32'h40 ^ 32'h5a5a, 32'h40, 8'h40};
      @(negedge CLK);
      issue(5'd2, 5'd3, 5'd6, 32'h44); bus.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         rf_rrs1 = $urandom; rf_rrs2 = $urandom;
         #1;
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b want 0", i, bus.in_ready); end
         @(negedge CLK);
         checks++; if (obs() !== held) begin errors++; $display("FAIL stall_hold cycle %0d got %h want %h", i, obs(), held); end
      end
      bus.out_ready = 1; rf_rrs1 = 32'h777;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", bus.in_ready); end
      @(negedge CLK);
      checks++; if ({bus.out_valid, bus.out_pc, bus.out_rs1_val} !== {1'b1, 32'h44, 32'h777}) begin errors++; $display("FAIL stall_next got %h want %h", {bus.out_valid, bus.out_pc, bus.out_rs1_val}, {1'b1, 32'h44, 32'h777}); end
   endtask

   task automatic test_flush();
      @(negedge CLK);
      idle(); issue(5'd1, 5'd2, 5'd3, 32'h80);
      @(negedge CLK);
      issue(5'd1, 5'd2, 5'd3, 32'h84); bus.out_ready = 0; flush = 1;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
      @(negedge CLK);
      checks++; if (bus.out_valid !== 1'b0 || bus.out_pc === 32'h84) begin errors++; $display("FAIL flush_drop got valid %b pc %h want valid 0 pc not 84", bus.out_valid, bus.out_pc); end
      flush = 0;
   endtask

   task automatic test_wrap();
      @(negedge CLK);
      idle();
      force dut.hazard_cnt = 32'hFFFFFFFF;
      #1 release dut.hazard_cnt;
      issue(5'd9, 5'd0, 5'd1, 32'h500); ex_valid = 1; ex_is_load = 1; ex_rd = 5'd9;
      @(negedge CLK);
      checks++; if (hazard_cnt !== 32'd0) begin errors++; $display("FAIL cnt_wrap got %h want 0", hazard_cnt); end
      flush = 1;
      @(negedge CLK);
      checks++; if (hazard_cnt !== 32'd0) begin errors++; $display("FAIL cnt_flush_no_count got %h want 0", hazard_cnt); end
      idle();
   endtask

   task automatic test_random();
      logic [31:0]  regs [32];
      logic [143:0] m_out;
      logic         m_valid, stall, exp_ready;
      logic [31:0]  m_cnt;
      foreach (regs[i]) regs[i] = $urandom;
      @(negedge CLK);
      idle(); RST = 1;
      @(negedge CLK);
      RST = 0; m_valid = 0; m_out = '0; m_cnt = 0;
      for (int n = 0; n < 400; n++) begin
         checks++;
         if ((m_valid ? obs() : {bus.out_valid, 143'd0}) !== (m_valid ? m_out : 144'd0)) begin
            errors++; $display("FAIL rand_out step %0d got %h want %h", n, obs(), m_valid ? m_out : 144'd0);
         end
         checks++; if (hazard_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt step %0d got %h want %h", n, hazard_cnt, m_cnt); end
         bus.in_valid = ($urandom % 4) != 0;
         bus.in_rs1 = 5'($urandom % 4); bus.in_rs2 = 5'($urandom % 4); bus.in_rd = 5'($urandom);
         bus.in_use_rs1 = ($urandom % 4) != 0; bus.in_use_rs2 = ($urandom % 4) != 0;
         bus.in_we = 1'($urandom); bus.in_is_load = 1'($urandom);
         bus.in_imm = $urandom; bus.in_pc = $urandom; bus.in_ctrl = 8'($urandom);
         rf_rrs1 = regs[bus.in_rs1]; rf_rrs2 = regs[bus.in_rs2];
         ex_valid = 1'($urandom); ex_is_load = 1'($urandom); ex_rd = 5'($urandom % 4); ex_data = $urandom;
         mem_valid = 1'($urandom); mem_rd = 5'($urandom % 4); mem_data = $urandom;
         wb_we = 1'($urandom); wb_rd = 5'($urandom % 4); wb_data = $urandom;
         flush = ($urandom % 10) == 0; bus.out_ready = ($urandom % 3) != 0;
         #1;
         stall = m_stall(bus.in_rs1, bus.in_use_rs1) || m_stall(bus.in_rs2, bus.in_use_rs2);
         exp_ready = (!m_valid || bus.out_ready) && !stall && !flush;
         checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rand_in_ready step %0d got %b want %b", n, bus.in_ready, exp_ready); end
         if (bus.in_valid && stall && !flush) m_cnt = m_cnt + 1;
         if (flush) m_valid = 0;
         else if (bus.in_valid && exp_ready) begin
            m_valid = 1;
            m_out = {1'b1, m_opnd(bus.in_rs1, rf_rrs1), m_opnd(bus.in_rs2, rf_rrs2), bus.in_rd, bus.in_we,
                     bus.in_is_load, bus.in_imm, bus.in_pc, bus.in_ctrl};
         end else if (bus.out_ready) m_valid = 0;
         if (wb_we && wb_rd != 0) regs[wb_rd] = wb_data;
         @(negedge CLK);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ex_priority();
      test_load_use();
      test_x0();
      test_stall();
      test_flush();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
